// File: rtl/alarm_unit.sv
// Alarm stage: stores an editable HH:MM alarm, rings a square-wave buzzer on a
// match with the running time of day, and supports snooze with hour carry.
module alarm_unit #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int TONE_DIV       = 24999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [4:0] hour_in,
    input  logic       sec_tick,
    input  logic       set_mode,
    input  logic       up_pulse,
    input  logic       down_pulse,
    input  logic       sel_pulse,
    input  logic       arm_pulse,
    input  logic       snooze_pulse,
    output logic [5:0] alarm_min,
    output logic [4:0] alarm_hour,
    output logic       edit_field,
    output logic       armed,
    output logic       ringing,
    output logic       buzzer
);

    localparam int TW = (TONE_DIV > 0) ? $clog2(TONE_DIV + 1) : 1;
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV);
    localparam logic [7:0]    RING_LAST = 8'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    alarmMin_q, alarmMin_d;
    logic [4:0]    alarmHour_q, alarmHour_d;
    logic          editField_q, editField_d;
    logic          armed_q, armed_d;
    logic          ringing_q, ringing_d;
    logic          buzzer_q, buzzer_d;
    logic [7:0]    ringCnt_q, ringCnt_d;
    logic [TW-1:0] toneCnt_q, toneCnt_d;
    logic [5:0]    snzMin_q, snzMin_d;
    logic [4:0]    snzHour_q, snzHour_d;

    logic       cancel;
    logic       alarmMatch;
    logic       snzMatch;
    logic [6:0] snzSum;
    logic       startRing;

    // set_mode can only be high in RINGING/SNOOZE if it rose there, since
    // both states are entered with set_mode low; the level is the rise.
    assign cancel     = set_mode | (arm_pulse & armed_q);
    assign alarmMatch = sec_tick && (sec_in == 6'd0) && (min_in == alarmMin_q)
                        && (hour_in == alarmHour_q);
    assign snzMatch   = sec_tick && (sec_in == 6'd0) && (min_in == snzMin_q)
                        && (hour_in == snzHour_q);
    assign snzSum     = {1'b0, min_in} + 7'(SNOOZE_MINUTES);

    always_comb begin
        state_d     = state_q;
        alarmMin_d  = alarmMin_q;
        alarmHour_d = alarmHour_q;
        editField_d = editField_q;
        armed_d     = armed_q ^ arm_pulse;
        ringCnt_d   = ringCnt_q;
        toneCnt_d   = toneCnt_q;
        buzzer_d    = buzzer_q;
        snzMin_d    = snzMin_q;
        snzHour_d   = snzHour_q;
        startRing   = 1'b0;

        if (set_mode) begin
            if (up_pulse && !down_pulse) begin
                if (editField_q)
                    alarmHour_d = (alarmHour_q == 5'd23) ? 5'd0 : alarmHour_q + 5'd1;
                else
                    alarmMin_d = (alarmMin_q == 6'd59) ? 6'd0 : alarmMin_q + 6'd1;
            end else if (down_pulse && !up_pulse) begin
                if (editField_q)
                    alarmHour_d = (alarmHour_q == 5'd0) ? 5'd23 : alarmHour_q - 5'd1;
                else
                    alarmMin_d = (alarmMin_q == 6'd0) ? 6'd59 : alarmMin_q - 6'd1;
            end
            if (sel_pulse)
                editField_d = ~editField_q;
        end

        case (state_q)
            IDLE: begin
                if (armed_q && !cancel && alarmMatch)
                    startRing = 1'b1;
            end
            RINGING: begin
                if (cancel) begin
                    state_d = IDLE;
                end else if (snooze_pulse) begin
                    state_d = SNOOZE;
                    if (snzSum >= 7'd60) begin
                        snzMin_d  = 6'(snzSum - 7'd60);
                        snzHour_d = (hour_in == 5'd23) ? 5'd0 : hour_in + 5'd1;
                    end else begin
                        snzMin_d  = snzSum[5:0];
                        snzHour_d = hour_in;
                    end
                end else if (sec_tick && (ringCnt_q == RING_LAST)) begin
                    state_d = IDLE;
                end else begin
                    if (sec_tick)
                        ringCnt_d = ringCnt_q + 8'd1;
                    if (toneCnt_q == TONE_LAST) begin
                        toneCnt_d = '0;
                        buzzer_d  = ~buzzer_q;
                    end else begin
                        toneCnt_d = toneCnt_q + 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (cancel)
                    state_d = IDLE;
                else if (snzMatch)
                    startRing = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Every entry to RINGING restarts the ring and tone timing from zero.
        if (startRing) begin
            state_d   = RINGING;
            ringCnt_d = '0;
            toneCnt_d = '0;
            buzzer_d  = 1'b0;
        end
        if (state_d != RINGING) begin
            ringCnt_d = '0;
            toneCnt_d = '0;
            buzzer_d  = 1'b0;
        end
        ringing_d = (state_d == RINGING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            alarmMin_q  <= '0;
            alarmHour_q <= '0;
            editField_q <= 1'b0;
            armed_q     <= 1'b0;
            ringing_q   <= 1'b0;
            buzzer_q    <= 1'b0;
            ringCnt_q   <= '0;
            toneCnt_q   <= '0;
            snzMin_q    <= '0;
            snzHour_q   <= '0;
        end else begin
            state_q     <= state_d;
            alarmMin_q  <= alarmMin_d;
            alarmHour_q <= alarmHour_d;
            editField_q <= editField_d;
            armed_q     <= armed_d;
            ringing_q   <= ringing_d;
            buzzer_q    <= buzzer_d;
            ringCnt_q   <= ringCnt_d;
            toneCnt_q   <= toneCnt_d;
            snzMin_q    <= snzMin_d;
            snzHour_q   <= snzHour_d;
        end
    end

    assign alarm_min  = alarmMin_q;
    assign alarm_hour = alarmHour_q;
    assign edit_field = editField_q;
    assign armed      = armed_q;
    assign ringing    = ringing_q;
    assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: edit table, hand-written ring/snooze/cancel sequences,
// then random stimulus against a minute-of-day reference model.
module tb_alarm_unit;

    localparam int TD = 3;
    localparam int RS = 3;
    localparam int SN = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] sec_in = '0;
    logic [5:0] min_in = '0;
    logic [4:0] hour_in = '0;
    logic       sec_tick = 1'b0;
    logic       set_mode = 1'b0;
    logic       up_pulse = 1'b0;
    logic       down_pulse = 1'b0;
    logic       sel_pulse = 1'b0;
    logic       arm_pulse = 1'b0;
    logic       snooze_pulse = 1'b0;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       edit_field;
    logic       armed;
    logic       ringing;
    logic       buzzer;

    always #5 clk = ~clk;

    alarm_unit #(.RING_SECONDS(RS), .SNOOZE_MINUTES(SN), .TONE_DIV(TD)) dut (
        .clk(clk), .reset(reset), .sec_in(sec_in), .min_in(min_in),
        .hour_in(hour_in), .sec_tick(sec_tick), .set_mode(set_mode),
        .up_pulse(up_pulse), .down_pulse(down_pulse), .sel_pulse(sel_pulse),
        .arm_pulse(arm_pulse), .snooze_pulse(snooze_pulse),
        .alarm_min(alarm_min), .alarm_hour(alarm_hour), .edit_field(edit_field),
        .armed(armed), .ringing(ringing), .buzzer(buzzer)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: times held as minute-of-day, buzzer derived from
    // elapsed cycles in the ring rather than a tone counter.
    int mMin = 0, mHour = 0, mSnzTarget = 0, mTicks = 0, mCycles = 0;
    bit mField = 0, mArmed = 0, mRinging = 0, mSnoozing = 0;

    typedef struct {
        bit sm, up, dn, sel, arm;
        int expMin, expHour;
        bit expField, expArmed;
    } editVec_t;
    editVec_t tbl[12];

    function automatic bit isMatch(int target);
        return sec_tick && (sec_in == 6'd0) && (int'(hour_in) * 60 + int'(min_in) == target);
    endfunction

    task automatic modelUpdate();
        bit cancel;
        bit startRing;
        int d;
        if (reset) begin
            mMin = 0; mHour = 0; mField = 0; mArmed = 0; mRinging = 0;
            mSnoozing = 0; mSnzTarget = 0; mTicks = 0; mCycles = 0;
            return;
        end
        cancel = set_mode || (arm_pulse && mArmed);
        startRing = 0;
        if (mRinging) begin
            if (cancel) mRinging = 0;
            else if (snooze_pulse) begin
                mRinging = 0;
                mSnoozing = 1;
                mSnzTarget = (int'(hour_in) * 60 + int'(min_in) + SN) % 1440;
            end else begin
                if (sec_tick) mTicks++;
                if (mTicks == RS) mRinging = 0;
                else mCycles++;
            end
        end else if (mSnoozing) begin
            if (cancel) mSnoozing = 0;
            else if (isMatch(mSnzTarget)) begin
                mSnoozing = 0;
                startRing = 1;
            end
        end else if (mArmed && !cancel && isMatch(mHour * 60 + mMin)) begin
            startRing = 1;
        end
        if (startRing) begin
            mRinging = 1; mTicks = 0; mCycles = 0;
        end
        if (set_mode) begin
            if (up_pulse != down_pulse) begin
                d = up_pulse ? 1 : -1;
                if (mField) mHour = (mHour + 24 + d) % 24;
                else mMin = (mMin + 60 + d) % 60;
            end
            if (sel_pulse) mField = !mField;
        end
        if (arm_pulse) mArmed = !mArmed;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int expBuz;
        expBuz = (mRinging && ((mCycles / (TD + 1)) % 2 == 1)) ? 1 : 0;
        cmp("alarm_min", int'(alarm_min), mMin);
        cmp("alarm_hour", int'(alarm_hour), mHour);
        cmp("edit_field", int'(edit_field), int'(mField));
        cmp("armed", int'(armed), int'(mArmed));
        cmp("ringing", int'(ringing), int'(mRinging));
        cmp("buzzer", int'(buzzer), expBuz);
    endtask

    // One clock: the model sees the same inputs as the DUT at the edge,
    // outputs are compared on the falling edge, then pulses are cleared.
    task automatic applyStimulus();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        checkOutput();
        up_pulse = 0; down_pulse = 0; sel_pulse = 0;
        arm_pulse = 0; snooze_pulse = 0; sec_tick = 0;
    endtask

    task automatic tick(input int h, input int m, input int s);
        hour_in = 5'(h); min_in = 6'(m); sec_in = 6'(s); sec_tick = 1;
        applyStimulus();
    endtask

    task automatic pulseArm();
        arm_pulse = 1;
        applyStimulus();
    endtask

    // Assumes a freshly reset alarm (00:00, minutes field selected).
    task automatic setAlarm(input int h, input int m);
        set_mode = 1;
        repeat (m) begin up_pulse = 1; applyStimulus(); end
        sel_pulse = 1; applyStimulus();
        repeat (h) begin up_pulse = 1; applyStimulus(); end
        sel_pulse = 1; applyStimulus();
        set_mode = 0;
        applyStimulus();
    endtask

    task automatic doReset();
        reset = 1;
        applyStimulus();
        reset = 0;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 1, 0, 0, 59, 0,  0, 0};
        tbl[1]  = '{1, 1, 0, 1, 0, 0,  0,  1, 0};
        tbl[2]  = '{1, 0, 1, 0, 0, 0,  23, 1, 0};
        tbl[3]  = '{1, 1, 1, 0, 0, 0,  23, 1, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0,  0,  1, 0};
        tbl[5]  = '{1, 0, 0, 1, 0, 0,  0,  0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0,  0,  0, 0};
        tbl[7]  = '{0, 0, 1, 1, 0, 0,  0,  0, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0,  0,  0, 1};
        tbl[9]  = '{1, 1, 0, 0, 0, 1,  0,  0, 1};
        tbl[10] = '{1, 0, 1, 0, 0, 0,  0,  0, 1};
        tbl[11] = '{1, 0, 0, 0, 1, 0,  0,  0, 0};

        @(negedge clk);
        reset = 1;
        applyStimulus();
        applyStimulus();
        cmp("reset_ringing", int'(ringing), 0);
        cmp("reset_armed", int'(armed), 0);
        reset = 0;

        for (int i = 0; i < 12; i++) begin
            set_mode = tbl[i].sm; up_pulse = tbl[i].up; down_pulse = tbl[i].dn;
            sel_pulse = tbl[i].sel; arm_pulse = tbl[i].arm;
            applyStimulus();
            cmp("tbl_min", int'(alarm_min), tbl[i].expMin);
            cmp("tbl_hour", int'(alarm_hour), tbl[i].expHour);
            cmp("tbl_field", int'(edit_field), int'(tbl[i].expField));
            cmp("tbl_armed", int'(armed), int'(tbl[i].expArmed));
        end
        set_mode = 0;
        applyStimulus();

        $display("[TB] trigger and timeout");
        setAlarm(7, 30);
        pulseArm();
        tick(7, 29, 59);
        cmp("pre_match_ringing", int'(ringing), 0);
        tick(7, 30, 0);
        cmp("match_ringing", int'(ringing), 1);
        cmp("entry_buzzer", int'(buzzer), 0);
        repeat (3) applyStimulus();
        cmp("buzzer_before_rise", int'(buzzer), 0);
        applyStimulus();
        cmp("buzzer_first_rise", int'(buzzer), 1);
        repeat (4) applyStimulus();
        cmp("buzzer_fall", int'(buzzer), 0);
        tick(7, 30, 1);
        tick(7, 30, 2);
        cmp("ring_before_timeout", int'(ringing), 1);
        tick(7, 30, 3);
        cmp("timeout_ringing", int'(ringing), 0);
        cmp("timeout_buzzer", int'(buzzer), 0);

        $display("[TB] snooze with hour carry");
        doReset();
        setAlarm(23, 58);
        pulseArm();
        tick(23, 57, 59);
        tick(23, 58, 0);
        cmp("snz_ring_start", int'(ringing), 1);
        repeat (2) applyStimulus();
        snooze_pulse = 1;
        tick(23, 58, 10);
        cmp("snooze_stops_ring", int'(ringing), 0);
        tick(23, 59, 0);
        cmp("no_ring_2359", int'(ringing), 0);
        tick(0, 3, 0);
        cmp("snooze_rering", int'(ringing), 1);

        $display("[TB] cancel paths");
        set_mode = 1;
        applyStimulus();
        cmp("setmode_cancel", int'(ringing), 0);
        set_mode = 0;
        applyStimulus();
        tick(23, 58, 0);
        cmp("ring_again", int'(ringing), 1);
        pulseArm();
        cmp("disarm_ringing", int'(ringing), 0);
        cmp("disarm_armed", int'(armed), 0);
        pulseArm();
        tick(23, 58, 0);
        arm_pulse = 1;
        snooze_pulse = 1;
        applyStimulus();
        cmp("arm_snooze_ringing", int'(ringing), 0);
        pulseArm();
        tick(0, 3, 0);
        cmp("arm_snooze_no_rering", int'(ringing), 0);

        $display("[TB] guards");
        set_mode = 1;
        tick(23, 58, 0);
        cmp("guard_setmode", int'(ringing), 0);
        set_mode = 0;
        tick(23, 58, 1);
        cmp("guard_sec1", int'(ringing), 0);
        pulseArm();
        tick(23, 58, 0);
        cmp("guard_disarmed", int'(ringing), 0);
        pulseArm();

        $display("[TB] reset mid-ring");
        tick(23, 58, 0);
        repeat (5) applyStimulus();
        cmp("pre_reset_buzzer", int'(buzzer), 1);
        reset = 1;
        applyStimulus();
        cmp("rst_ringing", int'(ringing), 0);
        cmp("rst_buzzer", int'(buzzer), 0);
        cmp("rst_armed", int'(armed), 0);
        cmp("rst_min", int'(alarm_min), 0);
        cmp("rst_hour", int'(alarm_hour), 0);
        cmp("rst_field", int'(edit_field), 0);
        reset = 0;
        applyStimulus();

        $display("[TB] random phase");
        pulseArm();
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int h;
            int m;
            if ($urandom_range(99) < 3) set_mode = !set_mode;
            up_pulse     = ($urandom_range(99) < 15);
            down_pulse   = ($urandom_range(99) < 15);
            sel_pulse    = ($urandom_range(99) < 8);
            arm_pulse    = ($urandom_range(99) < 3);
            snooze_pulse = ($urandom_range(99) < 6);
            reset        = ($urandom_range(999) < 3);
            if ($urandom_range(99) < 30) begin
                sel = int'($urandom_range(9));
                if (sel < 4) begin
                    h = mHour; m = mMin;
                end else if (sel < 7) begin
                    h = mSnzTarget / 60; m = mSnzTarget % 60;
                end else begin
                    h = int'($urandom_range(23)); m = int'($urandom_range(59));
                end
                hour_in = 5'(h);
                min_in  = 6'(m);
                sec_in  = ($urandom_range(3) == 0) ? 6'($urandom_range(59)) : 6'd0;
                sec_tick = 1;
            end
            applyStimulus();
        end
        reset = 0;
        set_mode = 0;
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
